// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronised sck/sdin, DATA_W-bit frames MSB first, one-entry transmit holding register.
// Optional slave select: define SPI_SLAVE_CS_EN to add the ss_n port and ss_n-framed transfers.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              sdin,
`ifdef SPI_SLAVE_CS_EN
  input  logic              ss_n,
`endif
  output logic              sdout,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, sdin_sync;
  logic                   sck_d;
  logic                   sck_s, sdin_s, sck_rise, sck_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_hold;

  logic frame_start, bit_rise, bit_fall, abort, last_bit;

  // Synchronisers shift towards the MSB; the top stage is the clean version of the pin.
  // NOTE: every register here uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      sdin_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= SYNC_STAGES'({sck_sync, sck});
      sdin_sync <= SYNC_STAGES'({sdin_sync, sdin});
      sck_d     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

`ifdef SPI_SLAVE_CS_EN
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   ss_d, ss_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync <= '1;
      ss_d    <= 1'b1;
    end else begin
      ss_sync <= SYNC_STAGES'({ss_sync, ss_n});
      ss_d    <= ss_s;
    end
  end

  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign frame_start = (state == IDLE) && !ss_s && ss_d;
  assign bit_rise    = (state == SHIFT) && !ss_s && sck_rise;
  assign bit_fall    = (state == SHIFT) && !ss_s && sck_fall;
  assign abort       = (state == SHIFT) && ss_s;
`else
  // Always selected: the first rising edge in IDLE opens the frame and is also bit 0.
  assign frame_start = (state == IDLE) && sck_rise;
  assign bit_rise    = sck_rise;
  assign bit_fall    = (state == SHIFT) && sck_fall;
  assign abort       = 1'b0;
`endif

  assign last_bit = bit_rise && (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is assigned a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start && !last_bit) state_nxt = SHIFT;
      SHIFT:   if (abort || last_bit)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift and holding registers are plain flops, so all of them are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // An empty holding register sends zeros rather than stale data.
      if (frame_start)   tx_shift <= tx_ready ? '0 : tx_hold;
      else if (bit_fall) tx_shift <= tx_shift << 1;

      if (bit_rise) rx_shift <= (rx_shift << 1) | DATA_W'(sdin_s);

      if (abort) begin
        bit_cnt <= '0;
      end else if (last_bit) begin
        bit_cnt  <= '0;
        rx_data  <= (rx_shift << 1) | DATA_W'(sdin_s);
        rx_valid <= 1'b1;
      end else if (bit_rise) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // The frame-start copy empties the holding register, so a load in that same clk is accepted.
      if (tx_load && (tx_ready || frame_start)) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end else if (frame_start) begin
        tx_ready <= 1'b1;
      end
    end
  end

  assign sdout = tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model plus an rx scoreboard queue.
// Builds with or without SPI_SLAVE_CS_EN; the ss_n scenarios run only when it is defined.
module tb_spi_slave;

  localparam int HALF = 8;  // sck half period in clk cycles

`ifdef SPI_SLAVE_CS_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       sdin = 1'b0;
  logic       sdout;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
`ifdef SPI_SLAVE_CS_EN
  logic       ss_n = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int rx_pulses = 0;
  int exp_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] miso;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .sdin     (sdin),
`ifdef SPI_SLAVE_CS_EN
    .ss_n     (ss_n),
`endif
    .sdout    (sdout),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle rx_valid is high consumes one expected frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_pulses++;
      if (exp_q.size() > 0) check("rx_frame", rx_data, exp_q.pop_front());
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Spans HALF clks from frame start; the optional load lands in the clk the slave copies its holding register.
  task automatic start_window(input bit inject, input logic [7:0] inj_val);
    repeat (2) @(negedge clk);
    if (inject) begin
      tx_data = inj_val;
      tx_load = 1'b1;
    end
    @(negedge clk);
    tx_load = 1'b0;
    repeat (HALF - 3) @(negedge clk);
  endtask

  // Master samples sdout at the end of each high phase, after the slave's synchronised update.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit inject,
                      input logic [7:0] inj_val, output logic [7:0] rx_bits);
    rx_bits = 8'h00;
    if (nbits == 8) begin
      exp_q.push_back(mosi);
      exp_pulses++;
    end
`ifdef SPI_SLAVE_CS_EN
    ss_n = 1'b0;
    start_window(inject, inj_val);
`endif
    for (int k = 0; k < nbits; k++) begin
      sdin = mosi[7-k];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      if (!CS_EN && k == 0) start_window(inject, inj_val);
      else                  repeat (HALF) @(negedge clk);
      rx_bits[7-k] = sdout;
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
`ifdef SPI_SLAVE_CS_EN
    ss_n = 1'b1;
    repeat (HALF) @(negedge clk);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    pulse_reset();
    check("rst_sdout", sdout, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);

    // Loaded byte goes out while 0x3C comes in
    load(8'hA5);
    check("load_tx_ready", tx_ready, 0);
    xfer(8'h3C, 8, 1'b0, 8'h00, miso);
    check("f1_miso", miso, 8'hA5);
    check("f1_rx_data", rx_data, 8'h3C);
    check("f1_tx_ready", tx_ready, 1);
    check("f1_pulses", rx_pulses, exp_pulses);

    // Empty holding register transmits zeros
    xfer(8'hFF, 8, 1'b0, 8'h00, miso);
    check("f2_miso", miso, 8'h00);
    check("f2_rx_data", rx_data, 8'hFF);

    // Second load while full is dropped
    load(8'h11);
    load(8'h22);
    check("full_tx_ready", tx_ready, 0);
    xfer(8'h96, 8, 1'b0, 8'h00, miso);
    check("f3_miso", miso, 8'h11);
    check("f3_tx_ready", tx_ready, 1);

    // Back-to-back frames without reading; nothing left to send
    xfer(8'h01, 8, 1'b0, 8'h00, miso);
    check("f4_miso", miso, 8'h00);
    xfer(8'h80, 8, 1'b0, 8'h00, miso);
    check("f5_miso", miso, 8'h00);
    check("f5_rx_data", rx_data, 8'h80);
    check("f5_pulses", rx_pulses, exp_pulses);

    // Load in the frame-start clk is kept for the next frame
    load(8'h5C);
    xfer(8'h24, 8, 1'b1, 8'hE7, miso);
    check("f6_miso", miso, 8'h5C);
    check("f6_tx_ready", tx_ready, 0);
    xfer(8'hB1, 8, 1'b0, 8'h00, miso);
    check("f7_miso", miso, 8'hE7);
    check("f7_rx_data", rx_data, 8'hB1);

    // Reset after four bits of a frame
    load(8'hFF);
    xfer(8'h0F, 4, 1'b1, 8'h42, miso);
    check("partial_miso", miso[7:4], 4'hF);
    pulse_reset();
    check("mid_rst_sdout", sdout, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_pulses", rx_pulses, exp_pulses);
    xfer(8'h5A, 8, 1'b0, 8'h00, miso);
    check("f8_miso", miso, 8'h00);
    check("f8_rx_data", rx_data, 8'h5A);
    check("f8_pulses", rx_pulses, exp_pulses);

`ifdef SPI_SLAVE_CS_EN
    // Slave select released after three bits aborts the frame
    xfer(8'hF0, 3, 1'b0, 8'h00, miso);
    check("abort_pulses", rx_pulses, exp_pulses);
    check("abort_rx_data", rx_data, 8'h5A);
    load(8'h3E);
    xfer(8'hC3, 8, 1'b0, 8'h00, miso);
    check("f9_miso", miso, 8'h3E);
    check("f9_rx_data", rx_data, 8'hC3);
    check("f9_pulses", rx_pulses, exp_pulses);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits (MSB first).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on sck, sdin and ss_n.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge; sck frequency is at most clk/8.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sck  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 sdin  input  1  master-out data, sampled on the synchronised sck rising edge.
REQ-007 sdout  output  1  slave-out data, changed on the synchronised sck falling edge.
REQ-008 tx_data  input  DATA_W  next byte to transmit.
REQ-009 tx_load  input  1  write strobe for tx_data; accepted only when tx_ready=1.
REQ-010 tx_ready  output  1  transmit holding register empty.
REQ-011 rx_data  output  DATA_W  last complete received frame.
REQ-012 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-013 ss_n  input  1  active-low slave select; this port is present only with SPI_SLAVE_CS_EN.

Function
REQ-014 sck, sdin and ss_n each pass through SYNC_STAGES flops; edges are detected against one further flop, giving pin-to-edge-detect latency SYNC_STAGES+1 clk.
REQ-015 FSM states: IDLE and SHIFT.
- IDLE -> SHIFT on frame start.
- SHIFT -> IDLE after the DATA_W-th rising edge.
REQ-016 Frame start copies the holding register into the tx shift register and sets tx_ready=1; sdout = shift[MSB] from the next clk.
REQ-017 If the holding register is empty at frame start, the shift register is loaded with all-zeros.
REQ-018 Each rising sck edge in SHIFT:
- shifts sdin into the rx shift register LSB;
- increments the 0..DATA_W-1 bit counter.
REQ-019 Each falling sck edge in SHIFT shifts the tx register left by one bit and drives the new MSB on sdout.
REQ-020 On the DATA_W-th rising edge, in the next clk:
- rx_data is set to the assembled frame;
- rx_valid=1 for exactly one clk;
- the counter wraps to 0.
REQ-021 rx_valid is not gated by any consumer handshake; an unread rx_data is overwritten silently.
REQ-022 tx_load with tx_ready=1 captures tx_data and clears tx_ready in the next clk.
REQ-023 tx_load with tx_ready=0 is ignored; the holding register is unchanged.
REQ-024 tx_load in the same clk as a frame-start copy is accepted into the now-empty holding register; the outgoing frame carries the old holding value.
REQ-025 sdout holds its last value in IDLE.

Reset
REQ-026 With rst=1 at a clk edge, the following take these values:
- state = IDLE, bit counter = 0, shift registers = 0;
- holding register = 0, synchroniser flops = 0 (ss_n synchronisers = 1);
- sdout = 0, tx_ready = 1, rx_data = 0, rx_valid = 0.
REQ-027 Reset in mid-frame abandons the partial frame; no rx_valid is produced for it.

Configuration
REQ-028 Macro SPI_SLAVE_CS_EN.
- Defined: ss_n exists. Its synchronised falling edge is the frame start.
- Defined: ss_n=1 in SHIFT aborts to IDLE next clk with counter 0 and no rx_valid. sck edges are ignored while ss_n=1.
- Undefined: no ss_n port; the slave is always selected.
- Undefined: frame start is the first rising sck edge seen in IDLE, and that edge is also processed as bit 0.

Verification
REQ-029 Load 0xA5, then the master clocks 8 bits of 0x3C -> master receives 0xA5; rx_data=0x3C; one rx_valid pulse; tx_ready=1.
REQ-030 No tx_load, master sends 0xFF -> master receives 0x00; rx_data=0xFF.
REQ-031 Load 0x11, then load 0x22 with tx_ready=0 -> the next frame transmits 0x11; 0x22 is discarded.
REQ-032 Two back-to-back frames 0x01 and 0x80 without reading -> two rx_valid pulses; rx_data ends at 0x80.
REQ-033 Assert rst after 4 sck edges of a frame -> all outputs take reset values; no rx_valid; the next full frame of 0x5A is received correctly.
REQ-034 With SPI_SLAVE_CS_EN: deassert ss_n after 3 bits -> FSM returns to IDLE with no rx_valid; a following ss_n frame of 0xC3 is received correctly.
